mdu_ctrl: RTL

//  Multiply/divide sequencer for the EX stage. Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO

---
 rtl/mdu_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the EX stage.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the EX instruction, runs an iterative
// shift-add multiplier or restoring divider, owns HI/LO, and stalls PC, IF/ID and ID/EX while
// an operation is in flight.
//
// Configuration macro: MDU_FAST_MUL_EN
//   defined   : MUL state lasts one cycle using a single DATA_W x DATA_W '*'.
//   undefined : iterative shift-add multiplier, one multiplier bit per cycle.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_instr       instruction currently in EX
//   i_rs_data     forwarded rs operand
//   i_rt_data     forwarded rt operand
//   i_flush       EX flush; kills the EX instruction and aborts an op in flight
//   o_mdu_stall   freeze PC, IF/ID, ID/EX this cycle
//   o_mdu_busy    FSM not in idle
//   o_hilo_rdata  HI for MFHI, LO for MFLO, else 0 (combinational)
module mdu_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              i_flush,
  output logic              o_mdu_stall,
  output logic              o_mdu_busy,
  output logic [DATA_W-1:0] o_hilo_rdata
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_hi, r_lo;
  // Shared work register: mul = {partial product, multiplier}; div = {remainder, dividend/quotient}
  logic [2*DATA_W-1:0]   r_prod;
  // Multiplicand for mul, divisor for div
  logic [DATA_W-1:0]     r_opb;
  logic                  r_is_mul;
  logic                  r_neg_q;  // product sign for mul, quotient sign for div
  logic                  r_neg_r;  // remainder sign for div

  // Decode
  logic       w_special;
  logic [5:0] w_funct;
  logic       w_op_mult, w_op_multu, w_op_div, w_op_divu;
  logic       w_op_mfhi, w_op_mflo, w_op_mthi, w_op_mtlo;
  logic       w_is_mul, w_md_op, w_start, w_signed;
  logic       w_unused_instr;

  assign w_special  = (i_instr[31:26] == 6'b000000);
  assign w_funct    = i_instr[5:0];
  assign w_op_mult  = w_special && (w_funct == 6'b011000);
  assign w_op_multu = w_special && (w_funct == 6'b011001);
  assign w_op_div   = w_special && (w_funct == 6'b011010);
  assign w_op_divu  = w_special && (w_funct == 6'b011011);
  assign w_op_mfhi  = w_special && (w_funct == 6'b010000);
  assign w_op_mflo  = w_special && (w_funct == 6'b010010);
  assign w_op_mthi  = w_special && (w_funct == 6'b010001);
  assign w_op_mtlo  = w_special && (w_funct == 6'b010011);
  assign w_is_mul   = w_op_mult | w_op_multu;
  assign w_md_op    = w_is_mul | w_op_div | w_op_divu;
  assign w_signed   = w_op_mult | w_op_div;
  assign w_start    = (r_state == StIdle) && w_md_op && !i_flush;
  assign w_unused_instr = ^i_instr[25:6];

  // Operand magnitudes; unsigned ops pass through raw
  logic              w_rs_neg, w_rt_neg, w_rt_zero;
  logic [DATA_W-1:0] w_rs_abs, w_rt_abs;

  assign w_rs_neg  = w_signed & i_rs_data[DATA_W-1];
  assign w_rt_neg  = w_signed & i_rt_data[DATA_W-1];
  assign w_rs_abs  = w_rs_neg ? -i_rs_data : i_rs_data;
  assign w_rt_abs  = w_rt_neg ? -i_rt_data : i_rt_data;
  assign w_rt_zero = (i_rt_data == '0);

  // Multiply step
  logic [2*DATA_W-1:0] w_mul_next;
  logic                w_mul_last;
`ifdef MDU_FAST_MUL_EN
  // Operands are magnitudes, so an unsigned product plus sign fix covers signed ops too
  assign w_mul_next = {{DATA_W{1'b0}}, r_prod[DATA_W-1:0]} * {{DATA_W{1'b0}}, r_opb};
  assign w_mul_last = 1'b1;
`else
  logic [DATA_W:0] w_mul_sum;
  assign w_mul_sum  = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                    + (r_prod[0] ? {1'b0, r_opb} : {(DATA_W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_prod[DATA_W-1:1]};
  assign w_mul_last = (r_cnt == CNT_W'(DATA_W - 1));
`endif

  // Restoring divide step: shift next dividend bit into remainder, subtract if it fits
  logic [DATA_W:0]     w_div_shift, w_div_diff;
  logic                w_div_ge;
  logic [2*DATA_W-1:0] w_div_next;
  logic                w_div_last;

  assign w_div_shift = {r_prod[2*DATA_W-1:DATA_W], r_prod[DATA_W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = !w_div_diff[DATA_W];
  assign w_div_next  = {(w_div_ge ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0]),
                        r_prod[DATA_W-2:0], w_div_ge};
  assign w_div_last  = (r_cnt == CNT_W'(DATA_W - 1));

  // Sign fix-up
  logic [2*DATA_W-1:0] w_prod_neg;
  logic [DATA_W-1:0]   w_fix_hi, w_fix_lo;

  assign w_prod_neg = -r_prod;

  always_comb begin
    w_fix_hi = r_prod[2*DATA_W-1:DATA_W];
    w_fix_lo = r_prod[DATA_W-1:0];
    if (r_is_mul) begin
      if (r_neg_q) begin
        w_fix_hi = w_prod_neg[2*DATA_W-1:DATA_W];
        w_fix_lo = w_prod_neg[DATA_W-1:0];
      end
    end else begin
      if (r_neg_r) w_fix_hi = -r_prod[2*DATA_W-1:DATA_W];
      if (r_neg_q) w_fix_lo = -r_prod[DATA_W-1:0];
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_state_next = r_state;
    o_mdu_stall  = 1'b0;
    o_mdu_busy   = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          o_mdu_stall = 1'b1;
          if (w_is_mul)       w_state_next = StMul;
          else if (w_rt_zero) w_state_next = StFix;
          else                w_state_next = StDiv;
        end
      end
      StMul: begin
        o_mdu_stall = !i_flush;
        if (i_flush)         w_state_next = StIdle;
        else if (w_mul_last) w_state_next = StFix;
      end
      StDiv: begin
        o_mdu_stall = !i_flush;
        if (i_flush)         w_state_next = StIdle;
        else if (w_div_last) w_state_next = StFix;
      end
      StFix: begin
        o_mdu_stall  = !i_flush;
        w_state_next = i_flush ? StIdle : StDone;
      end
      // Stall drops so the op leaves EX; nothing is accepted here
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_prod   <= '0;
      r_opb    <= '0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_cnt    <= '0;
            r_is_mul <= w_is_mul;
            if (w_is_mul) begin
              r_prod  <= {{DATA_W{1'b0}}, w_rt_abs};
              r_opb   <= w_rs_abs;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= 1'b0;
            end else if (w_rt_zero) begin
              // Divide by zero: fix-up passes these straight through to HI/LO
              r_prod  <= {i_rs_data, {DATA_W{1'b1}}};
              r_opb   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_prod  <= {{DATA_W{1'b0}}, w_rs_abs};
              r_opb   <= w_rt_abs;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= w_rs_neg;
            end
          end else if (!i_flush) begin
            if (w_op_mthi) r_hi <= i_rs_data;
            if (w_op_mtlo) r_lo <= i_rs_data;
          end
        end
        StMul: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        StDiv: begin
          r_prod <= w_div_next;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        StFix: begin
          if (!i_flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_hilo_rdata = '0;
    if (w_op_mfhi)      o_hilo_rdata = r_hi;
    else if (w_op_mflo) o_hilo_rdata = r_lo;
  end

endmodule
